// File: rtl/rs_latch_pkg.sv
// Shared types and constants for the gated RS latch sequencer.
// State encoding, op and grant-id values used by the controller and its arbiter.
package rs_latch_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StPulse = 3'd2,
    StHold  = 3'd3,
    StCheck = 3'd4
  } state_e;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  function automatic logic [CNT_W-1:0] cyc_to_cnt(input int unsigned n);
    return n[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/rs_latch_ctrl_if.sv
// Requester handshakes plus latch drive/feedback for rs_latch_ctrl.
// slave is the controller's view, master the environment's view.
interface rs_latch_ctrl_if;

  logic req_a;
  logic op_a;
  logic ack_a;
  logic req_b;
  logic op_b;
  logic ack_b;
  logic latch_s;
  logic latch_r;
  logic latch_en;
  logic q_in;
  logic busy;
  logic err;

  modport slave (
    input  req_a, op_a, req_b, op_b, q_in,
    output ack_a, ack_b, latch_s, latch_r, latch_en, busy, err
  );

  modport master (
    output req_a, op_a, req_b, op_b, q_in,
    input  ack_a, ack_b, latch_s, latch_r, latch_en, busy, err
  );

endinterface

// File: rtl/rs_latch_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-granted pointer.
// On a tie the requester that was not granted last wins.
module rr_arb2
  import rs_latch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic upd,
  input  logic upd_id,
  output logic gnt_valid,
  output logic gnt_id
);

  logic last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_B;
    end else if (upd) begin
      last_q <= upd_id;
    end
  end

  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_id    = GNT_A;
    if (req_a && req_b) begin
      gnt_id = (last_q == GNT_A) ? GNT_B : GNT_A;
    end else if (req_b) begin
      gnt_id = GNT_B;
    end
  end

endmodule

// File: rtl/rs_latch_ctrl.sv
// Sequencer for a shared gated RS latch: arbitrates two requesters, then drives
// setup / enable pulse / hold on s,r,en and checks q before acknowledging.
module rs_latch_ctrl
  import rs_latch_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic           clk,
  input  logic           rst,
  rs_latch_ctrl_if.slave bus
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_q;
  logic             gnt_q;
  logic             latch_s_q;
  logic             latch_r_q;
  logic             latch_en_q;
  logic             ack_a_q;
  logic             ack_b_q;
  logic             busy_q;
  logic             err_q;

  logic gnt_valid;
  logic gnt_id;
  logic gnt_op;
  logic upd;

  assign upd    = (state_q == StCheck);
  assign gnt_op = (gnt_id == GNT_A) ? bus.op_a : bus.op_b;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_a     (bus.req_a),
    .req_b     (bus.req_b),
    .upd       (upd),
    .upd_id    (gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Outputs are registered alongside the state, so each takes the value of the state being
  // entered. s and r are decoded from one op bit and can never both be high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= OP_RESET;
      gnt_q      <= GNT_A;
      latch_s_q  <= 1'b0;
      latch_r_q  <= 1'b0;
      latch_en_q <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            state_q   <= StSetup;
            cnt_q     <= cyc_to_cnt(SETUP_CYC);
            op_q      <= gnt_op;
            gnt_q     <= gnt_id;
            latch_s_q <= (gnt_op == OP_SET);
            latch_r_q <= (gnt_op == OP_RESET);
            busy_q    <= 1'b1;
          end
        end
        StSetup: begin
          if (cnt_q == cyc_to_cnt(1)) begin
            state_q    <= StPulse;
            cnt_q      <= cyc_to_cnt(PULSE_CYC);
            latch_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - cyc_to_cnt(1);
          end
        end
        StPulse: begin
          if (cnt_q == cyc_to_cnt(1)) begin
            state_q    <= StHold;
            cnt_q      <= cyc_to_cnt(HOLD_CYC);
            latch_en_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - cyc_to_cnt(1);
          end
        end
        StHold: begin
          if (cnt_q == cyc_to_cnt(1)) begin
            state_q <= StCheck;
            ack_a_q <= (gnt_q == GNT_A);
            ack_b_q <= (gnt_q == GNT_B);
            // q has settled by the end of hold; flag lands together with the ack
            if (bus.q_in != op_q) begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - cyc_to_cnt(1);
          end
        end
        StCheck: begin
          state_q   <= StIdle;
          latch_s_q <= 1'b0;
          latch_r_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q    <= StIdle;
          latch_s_q  <= 1'b0;
          latch_r_q  <= 1'b0;
          latch_en_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.latch_s  = latch_s_q;
  assign bus.latch_r  = latch_r_q;
  assign bus.latch_en = latch_en_q;
  assign bus.ack_a    = ack_a_q;
  assign bus.ack_b    = ack_b_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_rs_latch_ctrl.sv
// Directed bench for rs_latch_ctrl: default-parameter DUT plus a SETUP=3/PULSE=1/HOLD=2 DUT,
// each driving a behavioural gated RS latch, with an invariant checker on both.
module tb_rs_latch_ctrl;

  typedef struct packed {
    logic s;
    logic r;
    logic en;
    logic ack_a;
    logic ack_b;
    logic busy;
    logic err;
  } outs_t;

  typedef struct {
    logic  req_a;
    logic  op_a;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic lat0 = 1'b0;
  logic lat6 = 1'b0;
  logic force_q0 = 1'b0;
  logic rst_edge = 1'b1;

  rs_latch_ctrl_if if0 ();
  rs_latch_ctrl_if if6 ();

  rs_latch_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  rs_latch_ctrl #(
    .SETUP_CYC (3),
    .PULSE_CYC (1),
    .HOLD_CYC  (2)
  ) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (if6)
  );

  always #5 clk = ~clk;

  // Gated RS latch models: transparent while en is high
  always @(posedge clk) begin
    rst_edge <= rst;
    if (if0.latch_en) lat0 <= if0.latch_s ? 1'b1 : (if0.latch_r ? 1'b0 : lat0);
    if (if6.latch_en) lat6 <= if6.latch_s ? 1'b1 : (if6.latch_r ? 1'b0 : lat6);
  end

  assign if0.q_in = force_q0 ? 1'b0 : lat0;
  assign if6.q_in = lat6;

  function automatic outs_t sample(input int sel);
    outs_t o;
    if (sel == 0) begin
      o = {if0.latch_s, if0.latch_r, if0.latch_en, if0.ack_a, if0.ack_b, if0.busy, if0.err};
    end else begin
      o = {if6.latch_s, if6.latch_r, if6.latch_en, if6.ack_a, if6.ack_b, if6.busy, if6.err};
    end
    return o;
  endfunction

  task automatic check_outs(input string name, input outs_t got, input outs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got s,r,en,ack_a,ack_b,busy,err=%b required %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic check_inv(input string name, input outs_t cur, input outs_t prv);
    total++;
    if (cur.s && cur.r) begin
      bad++;
      $display("FAIL %s s&r: got s=%b r=%b required not both 1", name, cur.s, cur.r);
    end else if (cur.ack_a && cur.ack_b) begin
      bad++;
      $display("FAIL %s ack overlap: got ack_a=%b ack_b=%b required not both", name,
               cur.ack_a, cur.ack_b);
    end else if (!rst_edge && (cur.en || prv.en) && (cur.s != prv.s || cur.r != prv.r)) begin
      bad++;
      $display("FAIL %s sr stability: got s,r %b%b->%b%b around en required unchanged", name,
               prv.s, prv.r, cur.s, cur.r);
    end
  endtask

  outs_t prv0 = '0;
  outs_t prv6 = '0;

  always @(negedge clk) begin
    check_inv("inv dut0", sample(0), prv0);
    check_inv("inv dut6", sample(1), prv6);
    prv0 <= sample(0);
    prv6 <= sample(1);
  end

  // which: 0 ack_a, 1 ack_b, 2 latch_en (dut0). Returns at the negedge where it is seen.
  function automatic logic sig0(input int which);
    case (which)
      0:       return if0.ack_a;
      1:       return if0.ack_b;
      default: return if0.latch_en;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, input int budget);
    int n;
    n = 0;
    while (!sig0(which) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!sig0(which)) begin
      total++;
      bad++;
      $display("FAIL %s: timeout after %0d cycles, got 0 required 1", name, budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t t1[7];
  vec_t t6[9];

  initial begin
    int got;
    int cyc;
    int last_ack;
    int id;
    int first_id;
    int exp_rr[4];

    if0.req_a = 1'b0; if0.op_a = 1'b0; if0.req_b = 1'b0; if0.op_b = 1'b0;
    if6.req_a = 1'b0; if6.op_a = 1'b0; if6.req_b = 1'b0; if6.op_b = 1'b0;

    t1[0] = '{req_a: 1'b1, op_a: 1'b1, exp: 7'b0000000};
    t1[1] = '{req_a: 1'b1, op_a: 1'b1, exp: 7'b1000010};
    t1[2] = '{req_a: 1'b1, op_a: 1'b1, exp: 7'b1010010};
    t1[3] = '{req_a: 1'b1, op_a: 1'b1, exp: 7'b1010010};
    t1[4] = '{req_a: 1'b1, op_a: 1'b1, exp: 7'b1000010};
    t1[5] = '{req_a: 1'b0, op_a: 1'b1, exp: 7'b1001010};
    t1[6] = '{req_a: 1'b0, op_a: 1'b1, exp: 7'b0000000};

    t6[0] = '{req_a: 1'b1, op_a: 1'b1, exp: 7'b0000000};
    t6[1] = '{req_a: 1'b1, op_a: 1'b1, exp: 7'b1000010};
    t6[2] = '{req_a: 1'b1, op_a: 1'b1, exp: 7'b1000010};
    t6[3] = '{req_a: 1'b1, op_a: 1'b1, exp: 7'b1000010};
    t6[4] = '{req_a: 1'b1, op_a: 1'b1, exp: 7'b1010010};
    t6[5] = '{req_a: 1'b1, op_a: 1'b1, exp: 7'b1000010};
    t6[6] = '{req_a: 1'b1, op_a: 1'b1, exp: 7'b1000010};
    t6[7] = '{req_a: 1'b0, op_a: 1'b1, exp: 7'b1001010};
    t6[8] = '{req_a: 1'b0, op_a: 1'b1, exp: 7'b0000000};

    // Test 1: reset values, then a single SET from A
    do_reset();
    check_outs("reset dut0", sample(0), '0);
    check_outs("reset dut6", sample(1), '0);
    for (int i = 0; i < 7; i++) begin
      check_outs($sformatf("t1 cyc%0d", i), sample(0), t1[i].exp);
      if0.req_a = t1[i].req_a;
      if0.op_a  = t1[i].op_a;
      @(negedge clk);
    end

    // Test 2: both requesting continuously alternate A, B, A, B every 6 cycles
    do_reset();
    if0.req_a = 1'b1; if0.op_a = 1'b1;
    if0.req_b = 1'b1; if0.op_b = 1'b0;
    exp_rr = '{0, 1, 0, 1};
    got = 0; cyc = 0; last_ack = -1;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (if0.ack_a || if0.ack_b) begin
        id = if0.ack_b ? 1 : 0;
        check_int($sformatf("rr order %0d", got), id, exp_rr[got]);
        check_int($sformatf("rr op s %0d", got), int'(if0.latch_s), (id == 0) ? 1 : 0);
        if (got == 0) check_int("rr first ack cycle", cyc, 5);
        else check_int($sformatf("rr spacing %0d", got), cyc - last_ack, 6);
        last_ack = cyc;
        got++;
      end
    end
    check_int("rr ack count", got, 4);
    if0.req_a = 1'b0; if0.req_b = 1'b0;

    // Test 3: wrong q on a SET sets err, which stays through a later good op until reset
    do_reset();
    force_q0 = 1'b1;
    if0.req_a = 1'b1; if0.op_a = 1'b1;
    wait_sig("t3 ack_a", 0, 12);
    check_int("t3 err at ack", int'(if0.err), 1);
    if0.req_a = 1'b0;
    force_q0 = 1'b0;
    @(negedge clk);
    if0.req_b = 1'b1; if0.op_b = 1'b0;
    @(negedge clk);
    wait_sig("t3 ack_b", 1, 12);
    if0.req_b = 1'b0;
    check_int("t3 reset op r", int'(if0.latch_r), 1);
    @(negedge clk);
    check_int("t3 err sticky", int'(if0.err), 1);
    do_reset();
    check_int("t3 err cleared", int'(if0.err), 0);

    // Test 4: reset mid-pulse aborts with no ack; next lone B request is served
    do_reset();
    if0.req_a = 1'b1; if0.op_a = 1'b1;
    wait_sig("t4 en", 2, 8);
    rst = 1'b1;
    if0.req_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_outs("t4 after abort", sample(0), '0);
    if0.req_b = 1'b1; if0.op_b = 1'b0;
    first_id = -1;
    for (int n = 0; n < 12 && first_id < 0; n++) begin
      @(negedge clk);
      if (n == 0) check_outs("t4 b setup", sample(0), 7'b0100010);
      if (if0.ack_a) first_id = 0;
      else if (if0.ack_b) first_id = 1;
    end
    check_int("t4 post-reset ack id", first_id, 1);
    if0.req_b = 1'b0;

    // Test 5: req drop and op toggle after grant do not affect the operation
    do_reset();
    if0.req_a = 1'b1; if0.op_a = 1'b0;
    @(negedge clk);
    if0.req_a = 1'b0;
    wait_sig("t5 en", 2, 6);
    if0.op_a = 1'b1;
    wait_sig("t5 ack_a", 0, 8);
    check_outs("t5 at ack", sample(0), 7'b0101010);
    if0.op_a = 1'b0;

    // Test 6: SETUP=3, PULSE=1, HOLD=2 instance
    do_reset();
    for (int i = 0; i < 9; i++) begin
      check_outs($sformatf("t6 cyc%0d", i), sample(1), t6[i].exp);
      if6.req_a = t6[i].req_a;
      if6.op_a  = t6[i].op_a;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
